// File: rtl/pcie_us_cq_req_demux_pkg.sv
// Shared definitions for the CQ request demux and the CQ write/read engines:
// request-type encodings, descriptor field offsets and the demux FSM states.
package pcie_us_cq_req_demux_pkg;

  // CQ descriptor request-type encodings
  localparam logic [3:0] REQ_MEM_READ       = 4'h0;
  localparam logic [3:0] REQ_MEM_WRITE      = 4'h1;
  localparam logic [3:0] REQ_IO_READ        = 4'h2;
  localparam logic [3:0] REQ_IO_WRITE       = 4'h3;
  localparam logic [3:0] REQ_MEM_FETCH_ADD  = 4'h4;
  localparam logic [3:0] REQ_MEM_SWAP       = 4'h5;
  localparam logic [3:0] REQ_MEM_CAS        = 4'h6;
  localparam logic [3:0] REQ_MEM_READ_LOCK  = 4'h7;
  localparam logic [3:0] REQ_CFG_READ_0     = 4'h8;
  localparam logic [3:0] REQ_CFG_READ_1     = 4'h9;
  localparam logic [3:0] REQ_CFG_WRITE_0    = 4'hA;
  localparam logic [3:0] REQ_CFG_WRITE_1    = 4'hB;
  localparam logic [3:0] REQ_MSG            = 4'hC;
  localparam logic [3:0] REQ_MSG_VENDOR     = 4'hD;
  localparam logic [3:0] REQ_MSG_ATS        = 4'hE;

  // Request-type field location: beat 1 bits [14:11] on a 64-bit bus,
  // beat 0 bits [78:75] on 128/256-bit buses
  localparam int CQ_TYPE_WIDTH    = 4;
  localparam int CQ_TYPE_LSB_DW64 = 11;
  localparam int CQ_TYPE_LSB_WIDE = 75;

  // Demux FSM states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR2,
    ST_PASS_WR,
    ST_PASS_RD,
    ST_DROP,
    ST_FLUSH
  } cq_state_t;

  // Destination of a decoded request
  typedef enum logic [1:0] {
    CQ_ROUTE_WR,
    CQ_ROUTE_RD,
    CQ_ROUTE_DROP
  } cq_route_t;

  function automatic cq_route_t cq_decode_type(input logic [3:0] req_type);
    case (req_type)
      REQ_MEM_WRITE: return CQ_ROUTE_WR;
      REQ_MEM_READ:  return CQ_ROUTE_RD;
      default:       return CQ_ROUTE_DROP;
    endcase
  endfunction

endpackage

// File: rtl/pcie_us_cq_req_demux_axis_out_reg.sv
// One-entry registered AXI-stream output stage. Accepts a new beat whenever
// it is empty or its current beat is being taken in the same cycle.
module axis_out_reg #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = 2,
  parameter int USER_WIDTH = 85
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic [KEEP_WIDTH-1:0] s_tkeep,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tlast,
  input  logic [USER_WIDTH-1:0] s_tuser,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic [KEEP_WIDTH-1:0] m_tkeep,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic [USER_WIDTH-1:0] m_tuser
);

  assign s_tready = !m_tvalid || m_tready;

  // Occupancy flag: set on load, cleared when the downstream takes the beat
  always_ff @(posedge clk) begin
    if (rst) begin
      m_tvalid <= 1'b0;
    end else if (s_tvalid && s_tready) begin
      m_tvalid <= 1'b1;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

  // Payload capture; contents are don't-care while empty
  always_ff @(posedge clk) begin
    if (s_tvalid && s_tready) begin
      m_tdata <= s_tdata;
      m_tkeep <= s_tkeep;
      m_tlast <= s_tlast;
      m_tuser <= s_tuser;
    end
  end

endmodule

// File: rtl/pcie_us_cq_req_demux.sv
// UltraScale CQ request demux: decodes each TLP's request type and routes the
// whole TLP to the memory-write or memory-read stream; other types are
// consumed and reported on status_error_uncor.
module pcie_us_cq_req_demux
  import pcie_us_cq_req_demux_pkg::*;
#(
  parameter int AXIS_PCIE_DATA_WIDTH    = 64,
  parameter int AXIS_PCIE_KEEP_WIDTH    = AXIS_PCIE_DATA_WIDTH/32,
  parameter int AXIS_PCIE_CQ_USER_WIDTH = 85
) (
  input  logic                               clk,
  input  logic                               rst,

  input  logic [AXIS_PCIE_DATA_WIDTH-1:0]    s_axis_cq_tdata,
  input  logic [AXIS_PCIE_KEEP_WIDTH-1:0]    s_axis_cq_tkeep,
  input  logic                               s_axis_cq_tvalid,
  output logic                               s_axis_cq_tready,
  input  logic                               s_axis_cq_tlast,
  input  logic [AXIS_PCIE_CQ_USER_WIDTH-1:0] s_axis_cq_tuser,

  output logic [AXIS_PCIE_DATA_WIDTH-1:0]    m_axis_cq_wr_tdata,
  output logic [AXIS_PCIE_KEEP_WIDTH-1:0]    m_axis_cq_wr_tkeep,
  output logic                               m_axis_cq_wr_tvalid,
  input  logic                               m_axis_cq_wr_tready,
  output logic                               m_axis_cq_wr_tlast,
  output logic [AXIS_PCIE_CQ_USER_WIDTH-1:0] m_axis_cq_wr_tuser,

  output logic [AXIS_PCIE_DATA_WIDTH-1:0]    m_axis_cq_rd_tdata,
  output logic [AXIS_PCIE_KEEP_WIDTH-1:0]    m_axis_cq_rd_tkeep,
  output logic                               m_axis_cq_rd_tvalid,
  input  logic                               m_axis_cq_rd_tready,
  output logic                               m_axis_cq_rd_tlast,
  output logic [AXIS_PCIE_CQ_USER_WIDTH-1:0] m_axis_cq_rd_tuser,

  output logic                               status_error_uncor
);

  localparam int DW      = AXIS_PCIE_DATA_WIDTH;
  localparam int KW      = AXIS_PCIE_KEEP_WIDTH;
  localparam int UW      = AXIS_PCIE_CQ_USER_WIDTH;
  localparam bit IS_DW64 = (DW == 64);

  cq_state_t state, state_next;
  cq_route_t route, route_next, dec_route;

  // Holding register (64-bit bus only): one beat ahead of the output stage
  logic [DW-1:0] hold_tdata;
  logic [KW-1:0] hold_tkeep;
  logic [UW-1:0] hold_tuser;
  logic          hold_tlast;
  logic          hold_valid;

  logic [CQ_TYPE_WIDTH-1:0] beat_type;
  logic s_ready, accept;
  logic hold_load, hold_fwd, hold_clr;
  logic push_wr, push_rd, err_set;
  logic wr_in_ready, rd_in_ready, cur_rdy, dec_rdy;
  logic err_q;

  logic [DW-1:0] out_tdata;
  logic [KW-1:0] out_tkeep;
  logic [UW-1:0] out_tuser;
  logic          out_tlast;

  generate
    if (IS_DW64) begin : g_type_dw64
      assign beat_type = s_axis_cq_tdata[CQ_TYPE_LSB_DW64 +: CQ_TYPE_WIDTH];
    end else begin : g_type_wide
      assign beat_type = s_axis_cq_tdata[CQ_TYPE_LSB_WIDE +: CQ_TYPE_WIDTH];
    end
  endgenerate

  // On a 64-bit bus every output beat comes out of the holding register;
  // wider buses register the input beat straight into the output stage.
  assign out_tdata = IS_DW64 ? hold_tdata : s_axis_cq_tdata;
  assign out_tkeep = IS_DW64 ? hold_tkeep : s_axis_cq_tkeep;
  assign out_tuser = IS_DW64 ? hold_tuser : s_axis_cq_tuser;
  assign out_tlast = IS_DW64 ? hold_tlast : s_axis_cq_tlast;

  assign s_axis_cq_tready   = s_ready;
  assign status_error_uncor = err_q;

  // Next-state, input ready and output-stage push decode
  always_comb begin
    dec_route  = cq_decode_type(beat_type);
    cur_rdy    = (route == CQ_ROUTE_RD) ? rd_in_ready : wr_in_ready;
    case (dec_route)
      CQ_ROUTE_WR: dec_rdy = wr_in_ready;
      CQ_ROUTE_RD: dec_rdy = rd_in_ready;
      default:     dec_rdy = 1'b1;
    endcase

    state_next = state;
    route_next = route;
    s_ready    = 1'b0;
    hold_load  = 1'b0;
    hold_fwd   = 1'b0;
    hold_clr   = 1'b0;
    push_wr    = 1'b0;
    push_rd    = 1'b0;
    err_set    = 1'b0;

    // First pass: ready and holding-register drain
    if (IS_DW64) begin
      case (state)
        ST_IDLE:    s_ready = 1'b1;
        ST_HDR2:    s_ready = dec_rdy;
        ST_PASS_WR, ST_PASS_RD, ST_FLUSH: begin
          hold_fwd = hold_valid && cur_rdy && !rst;
          s_ready  = !hold_valid || hold_fwd;
        end
        ST_DROP:    s_ready = 1'b1;
        default:    s_ready = 1'b0;
      endcase
    end else begin
      case (state)
        ST_IDLE:    s_ready = dec_rdy;
        ST_PASS_WR, ST_PASS_RD: s_ready = cur_rdy;
        ST_DROP:    s_ready = 1'b1;
        default:    s_ready = 1'b0;
      endcase
    end
    if (rst) s_ready = 1'b0;
    accept = s_axis_cq_tvalid && s_ready;

    if (hold_fwd) begin
      push_wr = (route == CQ_ROUTE_WR);
      push_rd = (route == CQ_ROUTE_RD);
    end

    // Second pass: transitions
    if (IS_DW64) begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (s_axis_cq_tlast) begin
              err_set = 1'b1;
            end else begin
              hold_load  = 1'b1;
              state_next = ST_HDR2;
            end
          end
        end
        ST_HDR2: begin
          if (accept) begin
            if (dec_route == CQ_ROUTE_DROP) begin
              err_set    = 1'b1;
              hold_clr   = 1'b1;
              state_next = s_axis_cq_tlast ? ST_IDLE : ST_DROP;
            end else begin
              push_wr    = (dec_route == CQ_ROUTE_WR);
              push_rd    = (dec_route == CQ_ROUTE_RD);
              hold_load  = 1'b1;
              route_next = dec_route;
              if (s_axis_cq_tlast)
                state_next = ST_FLUSH;
              else
                state_next = (dec_route == CQ_ROUTE_WR) ? ST_PASS_WR : ST_PASS_RD;
            end
          end
        end
        ST_PASS_WR, ST_PASS_RD: begin
          if (accept) begin
            hold_load = 1'b1;
            if (s_axis_cq_tlast) state_next = ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          // The next TLP's beat 0 may enter as the final beat leaves
          if (!hold_valid || hold_fwd) state_next = ST_IDLE;
          if (accept) begin
            if (s_axis_cq_tlast) begin
              err_set = 1'b1;
            end else begin
              hold_load  = 1'b1;
              state_next = ST_HDR2;
            end
          end
        end
        ST_DROP: begin
          if (accept && s_axis_cq_tlast) state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (dec_route == CQ_ROUTE_DROP) begin
              err_set    = 1'b1;
              state_next = s_axis_cq_tlast ? ST_IDLE : ST_DROP;
            end else begin
              push_wr    = (dec_route == CQ_ROUTE_WR);
              push_rd    = (dec_route == CQ_ROUTE_RD);
              route_next = dec_route;
              if (s_axis_cq_tlast)
                state_next = ST_IDLE;
              else
                state_next = (dec_route == CQ_ROUTE_WR) ? ST_PASS_WR : ST_PASS_RD;
            end
          end
        end
        ST_PASS_WR, ST_PASS_RD: begin
          if (accept) begin
            push_wr = (route == CQ_ROUTE_WR);
            push_rd = (route == CQ_ROUTE_RD);
            if (s_axis_cq_tlast) state_next = ST_IDLE;
          end
        end
        ST_DROP: begin
          if (accept && s_axis_cq_tlast) state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // FSM, route, error pulse and holding-register occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      route      <= CQ_ROUTE_WR;
      hold_valid <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state <= state_next;
      route <= route_next;
      err_q <= err_set;
      if (hold_load) begin
        hold_valid <= 1'b1;
      end else if (hold_fwd || hold_clr) begin
        hold_valid <= 1'b0;
      end
    end
  end

  // Holding-register payload
  always_ff @(posedge clk) begin
    if (hold_load) begin
      hold_tdata <= s_axis_cq_tdata;
      hold_tkeep <= s_axis_cq_tkeep;
      hold_tuser <= s_axis_cq_tuser;
      hold_tlast <= s_axis_cq_tlast;
    end
  end

  axis_out_reg #(
    .DATA_WIDTH(DW),
    .KEEP_WIDTH(KW),
    .USER_WIDTH(UW)
  ) u_wr_reg (
    .clk      (clk),
    .rst      (rst),
    .s_tdata  (out_tdata),
    .s_tkeep  (out_tkeep),
    .s_tvalid (push_wr),
    .s_tready (wr_in_ready),
    .s_tlast  (out_tlast),
    .s_tuser  (out_tuser),
    .m_tdata  (m_axis_cq_wr_tdata),
    .m_tkeep  (m_axis_cq_wr_tkeep),
    .m_tvalid (m_axis_cq_wr_tvalid),
    .m_tready (m_axis_cq_wr_tready),
    .m_tlast  (m_axis_cq_wr_tlast),
    .m_tuser  (m_axis_cq_wr_tuser)
  );

  axis_out_reg #(
    .DATA_WIDTH(DW),
    .KEEP_WIDTH(KW),
    .USER_WIDTH(UW)
  ) u_rd_reg (
    .clk      (clk),
    .rst      (rst),
    .s_tdata  (out_tdata),
    .s_tkeep  (out_tkeep),
    .s_tvalid (push_rd),
    .s_tready (rd_in_ready),
    .s_tlast  (out_tlast),
    .s_tuser  (out_tuser),
    .m_tdata  (m_axis_cq_rd_tdata),
    .m_tkeep  (m_axis_cq_rd_tkeep),
    .m_tvalid (m_axis_cq_rd_tvalid),
    .m_tready (m_axis_cq_rd_tready),
    .m_tlast  (m_axis_cq_rd_tlast),
    .m_tuser  (m_axis_cq_rd_tuser)
  );

endmodule
